// File: rtl/mac_seq_ctrl_pkg.sv
// mac_seq_ctrl_pkg
// Shared definitions for the dot-product sequencer and its mac datapath.
//   state_t  : sequencer FSM encoding (also exposed on the dbg_state port)
//   LANE_W   : width of one packed lane
//   LANES    : lanes per 32-bit operand word
//   WORD_W   : width of one operand word
package mac_seq_ctrl_pkg;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = LANE_W * LANES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ACC   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_seq_ctrl_mac.sv
// mac
// Combinational 4-lane 8-bit multiply-accumulate.
//   a, b : packed operand words, lane i at [i*8 +: 8]
//   p    : accumulator input
//   c    : p + sum of lane products, truncated to 8 bits (wraps, no saturation)
module mac
  import mac_seq_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [LANE_W-1:0] p,
  output logic [LANE_W-1:0] c
);

  logic [2*LANE_W-1:0] prod;
  logic [LANE_W-1:0]   sum;

  // Only the low byte of each product can reach the 8-bit result, so the
  // running sum is kept at lane width and wraps naturally.
  always_comb begin
    prod = '0;
    sum  = p;
    for (int i = 0; i < LANES; i++) begin
      prod = (2*LANE_W)'(a[i*LANE_W +: LANE_W]) * (2*LANE_W)'(b[i*LANE_W +: LANE_W]);
      sum  = sum + prod[LANE_W-1:0];
    end
    c = sum;
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
// Sequencer that walks two vectors of len packed words through the mac
// datapath and returns the 8-bit dot product (plus init_p, mod 256).
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, len, init_p: start pulse (taken in IDLE only), vector length and
//                       initial accumulator, both latched on start
//   busy              : high whenever the FSM is not in IDLE
//   op_req, op_addr   : operand request and word index (stable while op_req)
//   op_valid, op_a/b  : operand return; op_valid only honoured while op_req
//   res_valid, result : dot-product result, held until res_ready
//   res_ready         : consumer accepts the result
//   stall_cnt         : FETCH cycles spent waiting for op_valid (only when
//                       MAC_SEQ_PERF_EN is defined)
//   dbg_state         : current FSM state encoding
//
// Handshakes: a transfer happens on a rising edge where both sides are high
// (op_req & op_valid for operands, res_valid & res_ready for the result).
// Once raised, op_req/op_addr and res_valid/result hold until that transfer.
//
// Build option: MAC_SEQ_PERF_EN adds the stall_cnt counter and port.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [LANE_W-1:0] init_p,
  output logic              busy,
  output logic              op_req,
  output logic [LEN_W-1:0]  op_addr,
  input  logic              op_valid,
  input  logic [WORD_W-1:0] op_a,
  input  logic [WORD_W-1:0] op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [LANE_W-1:0] result,
`ifdef MAC_SEQ_PERF_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic [1:0]        dbg_state
);

  state_t              state;
  state_t              state_nxt;
  logic [LANE_W-1:0]   acc;
  logic [LEN_W-1:0]    idx;
  logic [LEN_W-1:0]    len_q;
  logic [WORD_W-1:0]   a_q;
  logic [WORD_W-1:0]   b_q;
  logic [LANE_W-1:0]   mac_c;
  logic                last_word;

  mac u_mac (
    .a (a_q),
    .b (b_q),
    .p (acc),
    .c (mac_c)
  );

  // len_q >= 1 whenever ACC is reachable, so len_q-1 never underflows here;
  // comparing before incrementing keeps idx within 0..len_q-1.
  assign last_word = (idx == len_q - LEN_W'(1));
  assign dbg_state = state;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      idx   <= '0;
      len_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q <= len;
            acc   <= init_p;
            idx   <= '0;
          end
        end
        ST_FETCH: begin
          if (op_valid) begin
            a_q <= op_a;
            b_q <= op_b;
          end
        end
        ST_ACC: begin
          acc <= mac_c;
          if (!last_word) begin
            idx <= idx + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and Moore outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    op_req    = 1'b0;
    op_addr   = '0;
    res_valid = 1'b0;
    result    = '0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (len == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        op_req  = 1'b1;
        op_addr = idx;
        if (op_valid) begin
          state_nxt = ST_ACC;
        end
      end
      ST_ACC: begin
        state_nxt = last_word ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        result    = acc;
        // A start arriving together with res_ready is not captured: the
        // start decode only exists in IDLE.
        if (res_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef MAC_SEQ_PERF_EN
  // Operand stall counter: cleared by an accepted start, saturating,
  // and otherwise held so it can be read after the result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      stall_cnt <= '0;
    end else if (state == ST_FETCH && !op_valid && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl
// Directed bench for mac_seq_ctrl: a vector table of whole transactions
// (operands, waits, backpressure, expected result and latency) plus a
// hand-written mid-operation reset sequence.
module tb_mac_seq_ctrl;

  localparam int LEN_W = 8;
  localparam int MAX_CYC = 2000;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [7:0]        init_p;
  logic              busy;
  logic              op_req;
  logic [LEN_W-1:0]  op_addr;
  logic              op_valid;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic              res_valid;
  logic              res_ready;
  logic [7:0]        result;
  logic [1:0]        dbg_state;
`ifdef MAC_SEQ_PERF_EN
  logic [15:0]       stall_cnt;
`endif

  int total;
  int bad;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [LEN_W-1:0]  len;
    logic [7:0]        init_p;
    logic [3:0][31:0]  a;
    logic [3:0][31:0]  b;
    int                waits;
    int                bp;
    bit                start_in_fetch;
    bit                start_in_done;
    logic [7:0]        exp_res;
    int                exp_lat;
  } vec_t;

  vec_t vecs[7];

  mac_seq_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .init_p    (init_p),
    .busy      (busy),
    .op_req    (op_req),
    .op_addr   (op_addr),
    .op_valid  (op_valid),
    .op_a      (op_a),
    .op_b      (op_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
`ifdef MAC_SEQ_PERF_EN
    .stall_cnt (stall_cnt),
`endif
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [LEN_W-1:0] l, input logic [7:0] ip,
                              input logic [31:0] a0, input logic [31:0] b0,
                              input logic [31:0] a1, input logic [31:0] b1,
                              input logic [31:0] a2, input logic [31:0] b2,
                              input logic [31:0] a3, input logic [31:0] b3,
                              input int w, input int bp, input bit sf, input bit sd,
                              input logic [7:0] er, input int el);
    vec_t v;
    v.len = l; v.init_p = ip;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.waits = w; v.bp = bp; v.start_in_fetch = sf; v.start_in_done = sd;
    v.exp_res = er; v.exp_lat = el;
    return v;
  endfunction

  // Driver + checker for one full transaction. Inputs change on the falling
  // edge; cyc counts falling edges after the edge that samples start.
  task automatic run_txn(input vec_t v, input int id);
    int cyc;
    int w;
    int waits;
    int lat;
    bit done;
    logic [7:0] exp_r;
    exp_q.push_back(v.exp_res);
    @(negedge clk);
    start = 1'b1; len = v.len; init_p = v.init_p;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; w = 0; waits = 0; lat = 0; done = 1'b0;
    while (!done && cyc < MAX_CYC) begin
      if (cyc == 1 && v.start_in_fetch) begin
        start = 1'b1; len = 8'd1; init_p = 8'h33;
      end else begin
        start = 1'b0;
      end
      if (res_valid) begin
        done = 1'b1;
        lat = cyc;
      end else begin
        if (op_req) begin
          check($sformatf("v%0d op_addr", id), 32'(op_addr), 32'(w));
          if (waits < v.waits) begin
            op_valid = 1'b0;
            waits++;
          end else begin
            op_valid = 1'b1;
            op_a = v.a[w % 4];
            op_b = v.b[w % 4];
            w++;
            waits = 0;
          end
        end else begin
          // Junk operands with op_valid high while not requested.
          op_valid = 1'b1;
          op_a = 32'hFFFF_FFFF;
          op_b = 32'hFFFF_FFFF;
        end
        @(negedge clk);
        cyc++;
      end
    end
    op_valid = 1'b0;
    start = 1'b0;
    exp_r = exp_q.pop_front();
    if (!done) begin
      total++;
      bad++;
      $display("FAIL v%0d timeout: res_valid not seen within %0d cycles", id, MAX_CYC);
    end else begin
      check($sformatf("v%0d latency", id), 32'(lat), 32'(v.exp_lat));
      check($sformatf("v%0d result", id), 32'(result), 32'(exp_r));
      check($sformatf("v%0d words", id), 32'(w), 32'(v.len));
`ifdef MAC_SEQ_PERF_EN
      check($sformatf("v%0d stall_cnt", id), 32'(stall_cnt), 32'(v.waits * int'(v.len)));
`endif
      for (int i = 0; i < v.bp; i++) begin
        @(negedge clk);
        check($sformatf("v%0d bp res_valid", id), 32'(res_valid), 32'd1);
        check($sformatf("v%0d bp result", id), 32'(result), 32'(exp_r));
      end
      res_ready = 1'b1;
      if (v.start_in_done) begin
        start = 1'b1; len = 8'd1; init_p = 8'h77;
      end
      @(negedge clk);
      res_ready = 1'b0;
      start = 1'b0;
      check($sformatf("v%0d res_valid drop", id), 32'(res_valid), 32'd0);
      check($sformatf("v%0d idle busy", id), 32'(busy), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d stay idle", id), 32'(busy), 32'd0);
`ifdef MAC_SEQ_PERF_EN
      check($sformatf("v%0d stall_cnt hold", id), 32'(stall_cnt), 32'(v.waits * int'(v.len)));
`endif
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; len = '0; init_p = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;

    // Vector table: len, init_p, (a,b) x4, waits/word, bp cycles,
    // start-in-FETCH, start-in-DONE, expected result, expected latency.
    vecs[0] = mk(8'd1, 8'h00, 32'h04030201, 32'h01010101, 0, 0, 0, 0, 0, 0,
                 0, 0, 1'b0, 1'b0, 8'h0A, 3);
    vecs[1] = mk(8'd2, 8'h00, 32'h04030201, 32'h01010101, 32'h80808080, 32'h02020202,
                 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 8'h0A, 5);
    vecs[2] = mk(8'd0, 8'h55, 0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 1'b0, 1'b0, 8'h55, 1);
    vecs[3] = mk(8'd1, 8'h00, 32'h04030201, 32'h01010101, 0, 0, 0, 0, 0, 0,
                 3, 5, 1'b0, 1'b0, 8'h0A, 6);
    vecs[4] = mk(8'd2, 8'h00, 32'h04030201, 32'h01010101, 32'h80808080, 32'h02020202,
                 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 8'h0A, 5);
    // 0x10 + 0x14 + (3 + 0xFE) + (0x10+0x20+0x30+0x40) = 0xC5 mod 256
    vecs[5] = mk(8'd3, 8'h10, 32'h01010101, 32'h05050505, 32'hFF000001, 32'h02000003,
                 32'h10203040, 32'h01010101, 0, 0, 0, 2, 1'b0, 1'b0, 8'hC5, 7);
    // 255 words of 4 each: 1020 mod 256 = 0xFC
    vecs[6] = mk(8'd255, 8'h00, 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101,
                 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101,
                 0, 0, 1'b0, 1'b0, 8'hFC, 511);

    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset op_req", 32'(op_req), 32'd0);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset op_addr", 32'(op_addr), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
`ifdef MAC_SEQ_PERF_EN
    check("reset stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i], i);
    end

    // Reset during ACC of a len=4 run.
    @(negedge clk);
    start = 1'b1; len = 8'd4; init_p = 8'h11;
    @(negedge clk);
    start = 1'b0;
    check("rst seq fetch", 32'(op_req), 32'd1);
    op_valid = 1'b1; op_a = 32'h01010101; op_b = 32'h01010101;
    @(negedge clk);
    op_valid = 1'b0;
    check("rst seq in acc", 32'(dbg_state), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rst mid busy", 32'(busy), 32'd0);
    check("rst mid op_req", 32'(op_req), 32'd0);
    check("rst mid res_valid", 32'(res_valid), 32'd0);
    check("rst mid result", 32'(result), 32'd0);
    check("rst mid op_addr", 32'(op_addr), 32'd0);
    check("rst mid state", 32'(dbg_state), 32'd0);
`ifdef MAC_SEQ_PERF_EN
    check("rst mid stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after rst idle", 32'(busy), 32'd0);
    run_txn(vecs[0], 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer for the existing 4-lane 8-bit `mac` datapath. It computes the dot product of two vectors of `len` 32-bit words (4 packed 8-bit lanes each). For each word it fetches operands over a request/valid interface, drives `mac` with the running accumulator as `p`, and registers `mac.c` back into the accumulator. The final 8-bit result is returned over a valid/ready handshake. It sits between the operand buffers and the result consumer.

Parameters:
LEN_W, 8, width of `len` and `op_addr`; maximum vector length is 2^LEN_W-1 words.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset; asynchronous assert, active-low
start  in  1  start pulse; sampled only in IDLE
len  in  LEN_W  number of 32-bit words to process; latched on start
init_p  in  8  initial accumulator value; latched on start
busy  out  1  high in any state other than IDLE
op_req  out  1  operand request
op_addr  out  LEN_W  word index 0..len-1; stable while op_req is high
op_valid  in  1  operands present; honoured only while op_req=1
op_a  in  32  vector A word; lanes at [7:0], [15:8], [23:16], [31:24]
op_b  in  32  vector B word; same lane layout as op_a
res_valid  out  1  result available
res_ready  in  1  consumer accepts the result
result  out  8  dot-product result

Behaviour:
- Reset values, applied immediately on rst_n=0 regardless of clk:
  - state=IDLE; acc, idx, len_q, a_q, b_q all 0
  - busy, op_req, res_valid = 0; result = 0; op_addr = 0
- States and transitions:
  - IDLE: on start=1, latch len_q<=len, acc<=init_p, idx<=0.
    - len==0: go to DONE.
    - otherwise: go to FETCH.
  - FETCH: op_req=1, op_addr=idx.
    - On op_valid=1, capture a_q<=op_a, b_q<=op_b and go to ACC.
    - Otherwise remain in FETCH; any number of wait cycles is allowed.
  - ACC: op_req=0; acc <= mac(a_q, b_q, acc).c.
    - idx==len_q-1: go to DONE.
    - otherwise: idx<=idx+1, go to FETCH.
  - DONE: res_valid=1, result=acc.
    - On res_ready=1: go to IDLE; res_valid deasserts on the following cycle.
- Arithmetic:
  - `mac` is combinational on the registered a_q, b_q and acc; no extra pipeline stage.
  - Result = (init_p + Σ lane products) mod 256, i.e. wrap-around is inherited from `mac` truncation.
  - No saturation.
- Latency:
  - With zero-wait operands, res_valid rises 2*len+1 cycles after the clock edge that samples start.
  - len=0 gives 1 cycle, with result=init_p.
  - Each operand wait cycle adds 1.
- Boundary conditions:
  - start while busy is ignored; no re-latch.
  - start and res_ready both high in DONE: the transaction completes and returns to IDLE; that start is not captured. A new start must be presented in IDLE.
  - op_valid while op_req=0 is ignored.
  - len=2^LEN_W-1: idx reaches the maximum value without overflow.
  - result and res_valid are held stable under backpressure (res_ready=0).
  - rst_n low mid-operation aborts at once: all outputs return to reset values, acc is lost, and no partial result is delivered.

Optional Feature:
MAC_SEQ_PERF_EN
- Defined: adds output `stall_cnt` [15:0].
  - Counts cycles in FETCH with op_valid=0.
  - Cleared to 0 when start is accepted and on reset; saturates at 0xFFFF.
  - Holds its value after DONE until the next accepted start.
- Undefined: port and counter absent; all other behaviour is identical.

Decomposition:
- Shared package: state enum (IDLE, FETCH, ACC, DONE), lane width constant 8, lanes-per-word constant 4.
- Sub-module: instantiate the existing `mac` as the datapath. Control and the accumulator register stay in mac_seq_ctrl. No other sub-modules.

Test Plan:
1. len=1, init_p=0x00, op_a=0x04030201, op_b=0x01010101, op_valid same cycle as op_req → result=0x0A, res_valid 3 cycles after start.
2. len=2, init_p=0x00, word0 as in test 1, word1 op_a=0x80808080, op_b=0x02020202 → lane sum 0x400 wraps, result=0x0A, latency 5 cycles.
3. len=0, init_p=0x55 → no op_req, result=0x55 one cycle after start.
4. len=1, op_valid delayed 3 cycles, res_ready low 5 cycles → op_addr=0 held, result stable under backpressure, latency 6; with MAC_SEQ_PERF_EN, stall_cnt=3.
5. start pulsed during FETCH → ignored, original len completes; start with res_ready in DONE → not captured.
6. rst_n low during ACC of a len=4 run → outputs to reset values immediately; a subsequent len=1 run (test 1 operands) returns 0x0A.
